// File: rtl/shift_unit.sv
// Iterative one-bit-per-clock shifter/rotator with a start/busy/done handshake.
// Operand and shift count are captured on the accepted start edge; result holds until the next start.
module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic [1:0]         r_state;
  logic [SHAMT_W-1:0] r_count;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;

  logic [1:0]         w_state_nxt;
  logic [SHAMT_W-1:0] w_count_nxt;
  logic [2:0]         w_op_nxt;
  logic [WIDTH-1:0]   w_result_nxt;

  // Single-bit step; pass-through codes never reach SHIFT, so default holds the value.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] val, input logic [2:0] sel);
    logic [WIDTH-1:0] res;
    case (sel)
      OP_SLL:  res = {val[WIDTH-2:0], 1'b0};
      OP_SRL:  res = {1'b0, val[WIDTH-1:1]};
      OP_SRA:  res = {val[WIDTH-1], val[WIDTH-1:1]};
      OP_ROL:  res = {val[WIDTH-2:0], val[WIDTH-1]};
      OP_ROR:  res = {val[0], val[WIDTH-1:1]};
      default: res = val;
    endcase
    return res;
  endfunction

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_result_nxt = data_in;
          w_count_nxt  = shift_amt;
          w_op_nxt     = op;
          if ((shift_amt == {SHAMT_W{1'b0}}) || (op > OP_ROR)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_result_nxt = shift_one(r_result, r_op);
        w_count_nxt  = r_count - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (r_count == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers; busy/done are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_count  <= {SHAMT_W{1'b0}};
      r_op     <= 3'b000;
      r_result <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_op     <= w_op_nxt;
      r_result <= w_result_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit: latency, result, reset abort and start-while-busy.
module tb_shift_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shift_amt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk = 0;
  int n_err = 0;

  shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .data_in(data_in),
    .shift_amt(shift_amt), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after acceptance, and check latency/result/handshake.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] d,
                        input logic [4:0] a, input logic [31:0] exp, input int exp_lat);
    int lat;
    start = 1'b1; op = o; data_in = d; shift_amt = a;
    step();
    start = 1'b0; op = 3'b000; data_in = 32'h5A5A_A5A5; shift_amt = 5'd17;
    lat = 1;
    while (!done && lat < 40) begin
      check_eq({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
      step();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_result"}, result, exp);
    check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    step();
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int ndone;
    int done_lat;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; data_in = 32'd0; shift_amt = 5'd0;
    step();
    step();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    reset_n = 1'b1;
    step();

    run_op("sll4", 3'b000, 32'h0000_0001, 5'd4, 32'h0000_0010, 5);
    run_op("sra31", 3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
    run_op("srl31", 3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 32);
    run_op("ror1", 3'b100, 32'h0000_0001, 5'd1, 32'h8000_0000, 2);
    run_op("rol4", 3'b011, 32'h8000_0001, 5'd4, 32'h0000_0018, 5);
    run_op("sll0", 3'b000, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
    run_op("pass", 3'b111, 32'h1357_9BDF, 5'd9, 32'h1357_9BDF, 1);

    // Reset mid-SHIFT: outputs clear immediately and no stale done follows.
    start = 1'b1; op = 3'b000; data_in = 32'h0000_0001; shift_amt = 5'd20;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_result", result, 32'd0);
    #2;
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done || busy) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);

    // Start re-pulsed during SHIFT and DONE must be ignored.
    start = 1'b1; op = 3'b001; data_in = 32'hF000_0000; shift_amt = 5'd8;
    step();
    ndone = 0;
    done_lat = 0;
    for (int lat = 1; lat <= 9; lat++) begin
      if (done) begin
        ndone++;
        done_lat = lat;
      end
      start = (lat == 3 || lat == 9);
      op = 3'b000; data_in = 32'h1234_5678; shift_amt = 5'd3;
      step();
    end
    start = 1'b0;
    check_eq("busy_ign_ndone", ndone, 1);
    check_eq("busy_ign_lat", done_lat, 9);
    check_eq("busy_ign_result", result, 32'h00F0_0000);
    check_eq("busy_ign_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("busy_ign_idle_done", {31'd0, done}, 32'd0);
    run_op("next_accept", 3'b000, 32'h0000_0003, 5'd1, 32'h0000_0006, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
